// File: rtl/wallace_tree_accum_stage_if.sv
// Handshake/data bundle between the Wallace reduction layers, the accumulate stage and its consumer.
// master drives rows/start/out_ready; slave is the accumulate stage.
interface wallace_tree_accum_stage_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 24
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  sum_row;
  logic [IN_W-1:0]  carry_row;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             busy;

  modport master (
    output start, in_valid, sum_row, carry_row, out_ready,
    input  in_ready, out_valid, acc_out, overflow, busy
  );

  modport slave (
    input  start, in_valid, sum_row, carry_row, out_ready,
    output in_ready, out_valid, acc_out, overflow, busy
  );
endinterface

// File: rtl/wallace_tree_accum_stage.sv
// MAC back end: registered CPA of the final sum/carry rows, then accumulation of N_SAMPLES products.
// Define ACC_SATURATE_EN to clamp the accumulator instead of wrapping modulo 2^ACC_W.
module wallace_tree_accum_stage #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  wallace_tree_accum_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] N_CNT  = 8'(N_SAMPLES);
  localparam logic [7:0] N_LAST = 8'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IN_W:0]    cpa_q, cpa_d;
  logic             cpa_vld_q, cpa_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_c;
  logic             clear_c;
  logic [ACC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(cpa_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cpa_d      = cpa_q;
    cpa_vld_d  = 1'b0;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    in_ready_c = 1'b0;
    clear_c    = 1'b0;

    // Second pipeline stage: fold the previous cycle's CPA result into the accumulator.
    if (cpa_vld_q) begin
`ifdef ACC_SATURATE_EN
      if (acc_sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
`else
      acc_d = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) ovf_d = 1'b1;
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) clear_c = 1'b1;
      end
      S_ACCUM: begin
        in_ready_c = (cnt_q < N_CNT);
        if (bus.in_valid && in_ready_c) begin
          cpa_d     = {1'b0, bus.sum_row} + {1'b0, bus.carry_row};
          cpa_vld_d = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == N_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!cpa_vld_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.start)          clear_c = 1'b1;
        else if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A restart from DONE discards the held result exactly like a start from IDLE.
    if (clear_c) begin
      acc_d     = '0;
      ovf_d     = 1'b0;
      cnt_d     = '0;
      cpa_vld_d = 1'b0;
      state_d   = S_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cpa_q     <= '0;
      cpa_vld_q <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpa_q     <= cpa_d;
      cpa_vld_q <= cpa_vld_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
